// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder/decoder family: state encoding,
// default widths and a constant-foldable clog2.
package encoder_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int N_DEF    = 4;
  localparam int IDXW_DEF = clog2(N_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/encoder4x2_rr_pick.sv
// Combinational round-robin search: first set bit of pending at or above ptr,
// wrapping past N-1 back to 0.
module rr_pick import encoder_pkg::*; #(
  parameter int N    = N_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic [N-1:0]    pending,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  logic hit;
  int   j;

  always_comb begin
    idx = '0;
    hit = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!hit && pending[j]) begin
        hit = 1'b1;
        idx = IDXW'(j);
      end
    end
  end

  assign found = |pending;

endmodule

// File: rtl/encoder4x2_rr.sv
// Round-robin 4-to-2 encoder: sticky request latch, fair pick, and a
// valid/ready offer stage that forces one bubble cycle after each grant.
module encoder4x2_rr import encoder_pkg::*; #(
  parameter int N    = N_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            out_ready,
  output logic [IDXW-1:0] out,
  output logic            out_valid,
  output logic [N-1:0]    pending,
  output logic            ovf
);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] idx;
  logic            found;
  logic            hs;
  logic [N-1:0]    clr;
  logic [N-1:0]    pending_next;

  rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .idx     (idx),
    .found   (found)
  );

  assign hs = out_valid & out_ready;

  always_comb begin
    clr = '0;
    if (hs) clr[out] = 1'b1;
  end

  // A request landing on the bit being granted re-arms it (set wins).
  assign pending_next = (pending & ~clr) | req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      pending   <= '0;
      ovf       <= 1'b0;
    end else begin
      pending <= pending_next;
      if (|(req & pending & ~clr)) ovf <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            out       <= idx;
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (out_ready) begin
            ptr       <= (out == IDXW'(N - 1)) ? '0 : out + 1'b1;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder4x2_rr.sv
// Bench for encoder4x2_rr: cycle table plus hand sequences; grants are
// checked in order against a scoreboard queue at each handshake.
module tb_encoder4x2_rr;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] out;
  logic       out_valid;
  logic [3:0] pending;
  logic       ovf;

  int n_chk  = 0;
  int n_pass = 0;
  logic [1:0] sb[$];

  encoder4x2_rr dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .pending   (pending),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic       rd;
    logic       v;
    logic [1:0] o;
    logic [3:0] p;
    logic       f;
    int         pn;
    logic [7:0] pv;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic rd, logic v,
                              logic [1:0] o, logic [3:0] p, logic f,
                              int pn, logic [7:0] pv);
    vec_t t;
    t.r = r; t.rq = rq; t.rd = rd; t.v = v; t.o = o; t.p = p; t.f = f;
    t.pn = pn; t.pv = pv;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] o,
                         input logic [3:0] p, input logic f);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) check({tag, ".out"}, 32'(out), 32'(o));
    check({tag, ".pending"}, 32'(pending), 32'(p));
    check({tag, ".ovf"}, 32'(ovf), 32'(f));
  endtask

  // Scoreboard: every completed handshake must match the next expected grant.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) check("sb_unexpected_grant", 32'(out), 32'hFFFF_FFFF);
      else check("sb_grant", 32'(out), 32'(sb.pop_front()));
    end
  end

  vec_t tbl[18];

  initial begin
    tbl[0]  = mk(0, 4'b0100, 1, 0, 2'd0, 4'b0100, 0, 1, 8'h02);
    tbl[1]  = mk(0, 4'b0000, 1, 1, 2'd2, 4'b0100, 0, 0, 8'h00);
    tbl[2]  = mk(0, 4'b0000, 1, 0, 2'd2, 4'b0000, 0, 0, 8'h00);
    tbl[3]  = mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0, 0, 8'h00);
    tbl[4]  = mk(0, 4'b1111, 1, 0, 2'd0, 4'b1111, 0, 4, 8'hE4);
    tbl[5]  = mk(0, 4'b0000, 1, 1, 2'd0, 4'b1111, 0, 0, 8'h00);
    tbl[6]  = mk(0, 4'b0000, 1, 0, 2'd0, 4'b1110, 0, 0, 8'h00);
    tbl[7]  = mk(0, 4'b0000, 1, 1, 2'd1, 4'b1110, 0, 0, 8'h00);
    tbl[8]  = mk(0, 4'b0000, 1, 0, 2'd1, 4'b1100, 0, 0, 8'h00);
    tbl[9]  = mk(0, 4'b0000, 1, 1, 2'd2, 4'b1100, 0, 0, 8'h00);
    tbl[10] = mk(0, 4'b0000, 1, 0, 2'd2, 4'b1000, 0, 0, 8'h00);
    tbl[11] = mk(0, 4'b0000, 1, 1, 2'd3, 4'b1000, 0, 0, 8'h00);
    tbl[12] = mk(0, 4'b0000, 1, 0, 2'd3, 4'b0000, 0, 0, 8'h00);
    // ptr must be back at 0: 4'b1001 grants 0 before 3
    tbl[13] = mk(0, 4'b1001, 1, 0, 2'd3, 4'b1001, 0, 2, 8'h0C);
    tbl[14] = mk(0, 4'b0000, 1, 1, 2'd0, 4'b1001, 0, 0, 8'h00);
    tbl[15] = mk(0, 4'b0000, 1, 0, 2'd0, 4'b1000, 0, 0, 8'h00);
    tbl[16] = mk(0, 4'b0000, 1, 1, 2'd3, 4'b1000, 0, 0, 8'h00);
    tbl[17] = mk(0, 4'b0000, 1, 0, 2'd3, 4'b0000, 0, 0, 8'h00);

    // Reset with all requests high
    rst = 1'b1; req = 4'b1111; out_ready = 1'b0;
    step(); step();
    check("rst.out", 32'(out), 32'd0);
    chk_out("rst", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Single pulse, reset, round-robin, ptr wrap
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].r; req = tbl[i].rq; out_ready = tbl[i].rd;
      for (int k = 0; k < tbl[i].pn; k++) sb.push_back(tbl[i].pv[2*k +: 2]);
      step();
      chk_out($sformatf("row%0d", i), tbl[i].v, tbl[i].o, tbl[i].p, tbl[i].f);
    end

    // Backpressure with a repeated pulse on a pending bit
    rst = 1'b0; out_ready = 1'b0; req = 4'b0010; sb.push_back(2'd1);
    step();
    chk_out("bp.latch", 1'b0, 2'd0, 4'b0010, 1'b0);
    req = 4'b0000;
    step();
    chk_out("bp.offer", 1'b1, 2'd1, 4'b0010, 1'b0);
    for (int c = 0; c < 5; c++) begin
      req = (c == 2) ? 4'b0010 : 4'b0000;
      step();
      check($sformatf("bp.hold%0d.valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp.hold%0d.out", c), 32'(out), 32'd1);
    end
    check("bp.ovf", 32'(ovf), 32'd1);
    req = 4'b0000; out_ready = 1'b1;
    step();
    chk_out("bp.done", 1'b0, 2'd0, 4'b0000, 1'b1);
    step();
    chk_out("bp.nosecond", 1'b0, 2'd0, 4'b0000, 1'b1);

    // Clear/set collision on the granted bit
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0; req = 4'b1000; sb.push_back(2'd3); sb.push_back(2'd3);
    step();
    req = 4'b0000;
    step();
    chk_out("col.offer", 1'b1, 2'd3, 4'b1000, 1'b0);
    req = 4'b1000; out_ready = 1'b1;
    step();
    chk_out("col.hs", 1'b0, 2'd0, 4'b1000, 1'b0);
    req = 4'b0000;
    step();
    chk_out("col.reoffer", 1'b1, 2'd3, 4'b1000, 1'b0);
    step();
    chk_out("col.done", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Move ptr to 1, then reset in the middle of an offer of 2
    req = 4'b0001; sb.push_back(2'd0);
    step();
    req = 4'b0000;
    step(); step();
    chk_out("rmo.pre", 1'b0, 2'd0, 4'b0000, 1'b0);
    out_ready = 1'b0; req = 4'b0101;
    step();
    req = 4'b0000;
    step();
    chk_out("rmo.offer", 1'b1, 2'd2, 4'b0101, 1'b0);
    rst = 1'b1;
    step();
    check("rmo.rst.out", 32'(out), 32'd0);
    chk_out("rmo.rst", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0; req = 4'b0101; out_ready = 1'b1;
    sb.push_back(2'd0); sb.push_back(2'd2);
    step();
    req = 4'b0000;
    step();
    chk_out("rmo.first", 1'b1, 2'd0, 4'b0101, 1'b0);
    step(); step();
    chk_out("rmo.second", 1'b1, 2'd2, 4'b0100, 1'b0);
    step();
    chk_out("rmo.done", 1'b0, 2'd0, 4'b0000, 1'b0);

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/encoder4x2_rr.md
# encoder4x2_rr

Round-robin 4-to-2 encoder, the encode-side counterpart of the 2x4 decoder: it turns a 4-bit request vector back into a 2-bit index. Request pulses are latched sticky so none are lost. The block presents one encoded index at a time to a downstream consumer through a valid/ready handshake. Fairness comes from a round-robin pointer that advances past each accepted index.

## Interface
- N, 4, number of request lines; only 4 is verified.
- IDXW, 2, index width, equal to clog2(N).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request lines, sampled every cycle; pulses or levels.
- out_ready  input  1  consumer accepts `out` this cycle.
- out  output  IDXW  encoded index of the granted request.
- out_valid  output  1  `out` holds a valid index.
- pending  output  N  registered sticky request vector (observability).
- ovf  output  1  sticky flag: a request was re-asserted while still pending.

## Operation
- Reset (rst=1 at an edge):
  - out=0, out_valid=0, pending=0, ovf=0.
  - Pointer ptr=0, state=IDLE.
  - Reset overrides every other input, including an offer in flight, which is dropped.
- Pending update each edge:
  - pending_next = (pending & ~clr) | req.
  - clr is the one-hot of `out` when a handshake completes (out_valid & out_ready), otherwise 0.
  - If the bit being cleared is also set in req that same cycle, it stays set; set wins.
- ovf is set when req[i]=1 and pending[i]=1 and that bit is not being cleared this cycle. It never clears except by reset.
- Round-robin pick:
  - Search pending starting at index ptr, upward with wrap (ptr, ptr+1, …, N-1, 0, …).
  - The first set bit gives idx; found=|pending.
- FSM states: IDLE, OFFER.
  - IDLE:
    - If found: out<=idx, out_valid<=1, go to OFFER.
    - Else stay in IDLE with out_valid=0.
  - OFFER:
    - out and out_valid hold stable while out_ready=0.
    - On out_ready=1: clear pending[out], ptr<=(out+1) mod N, out_valid<=0, go to IDLE.
    - `out` keeps its last value after the handshake. It is don't-care when out_valid=0, but must not be X.
- out_ready while out_valid=0 is ignored.
- Index arithmetic is modulo N; ptr wraps 3→0.

## Timing
- Request to valid: a req bit first high at edge k is in pending after edge k. out_valid rises after edge k+1. Minimum latency is 2 cycles.
- Handshake: completes at the edge where out_valid=1 and out_ready=1. out_valid is 0 for the following cycle, which is a mandatory bubble.
- Throughput: at most one index every 2 cycles.
- Valid/out stability: once out_valid=1, `out` must not change until the handshake edge. A new higher-priority request never preempts an active offer.
- Simultaneous requests: all bits latch in the same cycle and are granted in round-robin order, one per handshake.
- Backpressure: with out_ready held low, pending accumulates. Repeated pulses on a pending bit set ovf.
- Reset mid-OFFER: out_valid=0 in the cycle after the reset edge. Pending contents are lost.

## Structure
- Shared package encoder_pkg holds:
  - the state encoding constants (IDLE=1'b0, OFFER=1'b1);
  - the default N and IDXW;
  - a clog2 function used by the decoder/encoder family.
- Sub-module rr_pick is purely combinational:
  - inputs pending[N-1:0] and ptr[IDXW-1:0];
  - outputs idx[IDXW-1:0] and found.
- The top level holds the pending register, ptr, FSM, output registers and ovf.

## Test plan
- Reset: drive rst=1 for 2 cycles with req=4'b1111. Required after the reset: out=0, out_valid=0, pending=0, ovf=0.
- Single pulse: req=4'b0100 for one cycle at edge k, out_ready=1. Required: out_valid high in cycle k+2 with out=2'b10, then pending=0 and out_valid=0 in the next cycle.
- Round-robin: req=4'b1111 for one cycle, out_ready=1. Required: outputs 0, 1, 2, 3 on successive offers, each separated by one bubble, ending with ptr=0.
- Backpressure and ovf: req=4'b0010 pulsed, out_ready=0 for 5 cycles, req=4'b0010 pulsed again. Required: out=1 held stable with out_valid=1 throughout, and ovf=1. After out_ready=1, a single grant and pending=0.
- Clear/set collision: while offering out=3, assert req=4'b1000 in the same cycle as out_ready=1. Required: pending[3] stays 1, ovf stays 0, and the next offer is again out=3.
- Reset mid-offer: assert rst while out_valid=1, out=2. Required: out_valid=0 next cycle, pending=0, and the first grant after the reset is chosen starting from ptr=0.
